// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller driving an external 1-bit full adder, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` input for A - B.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1; the final carry is the inverted borrow.
    assign b_load = sub ? ~B : B;
    assign c_load = sub ? 1'b1 : Cin;
`else
    assign b_load = B;
    assign c_load = Cin;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_carry;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign Sum   = sum_q;
    assign Carry = carry_q;
    // Full-adder drive is gated so it reads as zero outside RUN.
    assign fa_a  = busy_q & a_q[0];
    assign fa_b  = busy_q & b_q[0];
    assign fa_c  = busy_q & carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8) with a behavioural full adder.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, Cin;
    logic [7:0] A, B;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif
    logic       busy, done, Carry, fa_a, fa_b, fa_c, fa_sum, fa_carry;
    logic [7:0] Sum;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    assign fa_sum   = fa_a ^ fa_b ^ fa_c;
    assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .Sum(Sum), .Carry(Carry),
        .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
        .fa_sum(fa_sum), .fa_carry(fa_carry)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected {Carry,Sum}.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result: unexpected done with {C,S}=0x%0h, nothing expected", {Carry, Sum});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({Carry, Sum} !== e) begin
                    errors++;
                    $display("FAIL result: got {C,S}=0x%0h expected 0x%0h", {Carry, Sum}, e);
                end
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_in_done: got %0b expected 0", busy);
                end
            end
        end
    end

    // Issue one operation; restart_at>0 re-pulses start at that RUN cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic s, input logic [8:0] exp, input int restart_at);
        int edges, busy_cyc, d0;
        bit got;
        @(negedge clk);
        A = a; B = b; Cin = c;
`ifdef SERIAL_ADDER_SUB_EN
        sub = s;
`else
        if (s) $display("note: sub requested without SERIAL_ADDER_SUB_EN");
`endif
        start = 1'b1;
        exp_q.push_back(exp);
        d0 = done_cnt;
        edges = 0; busy_cyc = 0; got = 0;
        while (edges < 40 && !got) begin
            @(negedge clk);
            edges++;
            start = 1'b0;
            A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub = 1'($urandom);
`endif
            if (done) got = 1;
            else if (busy) begin
                busy_cyc++;
                if (busy_cyc == restart_at) start = 1'b1;
            end
        end
        chk("done_latency", edges, 9);
        chk("busy_cycles", busy_cyc, 8);
        repeat (12) @(negedge clk);
        chk("done_pulses", done_cnt - d0, 1);
        chk("sum_hold", {Carry, Sum}, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum", Sum, 0);
        chk("reset_carry", Carry, 0);
        chk("reset_fa", {fa_a, fa_b, fa_c}, 0);
        rst = 1'b0;

        run_op(8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 9'h100, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 3);
        run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 9'h04B, 0);
        run_op(8'h80, 8'h80, 1'b1, 1'b0, 9'h101, 0);
        chk("idle_fa", {fa_a, fa_b, fa_c}, 0);

        // Abort mid-RUN: state must clear and no done may follow.
        begin
            int busy_cyc, d0, guard;
            @(negedge clk);
            A = 8'hFF; B = 8'hFF; Cin = 1'b1; start = 1'b1;
            d0 = done_cnt; busy_cyc = 0; guard = 0;
            while (busy_cyc < 4 && guard < 20) begin
                @(negedge clk);
                start = 1'b0;
                guard++;
                if (busy) busy_cyc++;
            end
            chk("abort_reach_run4", busy_cyc, 4);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_sum", Sum, 0);
            chk("abort_carry", Carry, 0);
            chk("abort_fa", {fa_a, fa_b, fa_c}, 0);
            repeat (15) @(negedge clk);
            chk("abort_no_done", done_cnt - d0, 0);
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, 0);
        run_op(8'h00, 8'h01, 1'b1, 1'b1, 9'h0FF, 0);
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
